// File: rtl/nand_pkg.sv
// Shared definitions for the NAND target responders: opcodes, status bits, state codes.
package nand_pkg;

  localparam logic [7:0] CMD_ERASE1 = 8'h60;
  localparam logic [7:0] CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] CMD_STATUS = 8'h70;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // Status byte bit positions.
  localparam int SB_WP   = 7;
  localparam int SB_RDY  = 6;
  localparam int SB_ARDY = 5;
  localparam int SB_FAIL = 0;

  // State codes shared with the controller-side FSMs.
  localparam logic [3:0] ST_IDLE       = 4'h0;
  localparam logic [3:0] ST_ADDR1      = 4'h1;
  localparam logic [3:0] ST_ADDR2      = 4'h2;
  localparam logic [3:0] ST_ADDR3      = 4'h3;
  localparam logic [3:0] ST_CONFIRM    = 4'h4;
  localparam logic [3:0] ST_BUSY_ERASE = 4'h5;
  localparam logic [3:0] ST_BUSY_RST   = 4'h6;

  typedef enum logic [3:0] {
    IDLE       = ST_IDLE,
    ADDR1      = ST_ADDR1,
    ADDR2      = ST_ADDR2,
    ADDR3      = ST_ADDR3,
    CONFIRM    = ST_CONFIRM,
    BUSY_ERASE = ST_BUSY_ERASE,
    BUSY_RST   = ST_BUSY_RST
  } state_t;

  // Assemble the status byte; unused bits read as zero.
  function automatic logic [7:0] status_byte(input logic wp, input logic rb, input logic fail);
    logic [7:0] s;
    s          = 8'h00;
    s[SB_WP]   = wp;
    s[SB_RDY]  = rb;
    s[SB_ARDY] = rb;
    s[SB_FAIL] = fail;
    return s;
  endfunction

endpackage

// File: rtl/nand_busy_timer.sv
// Loadable down-counter that times R/B busy windows; done while the count sits at zero.
module nand_busy_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and hold at zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/nand_erase_target.sv
// NAND target responder: decodes block erase, read status and reset, drives R/B and status.
module nand_erase_target
  import nand_pkg::*;
#(
  parameter int BUSY_CYCLES = 16,
  parameter int RST_CYCLES  = 4,
  parameter int NUM_BLOCKS  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        cle,
  input  logic        ale,
  input  logic        wr,
  input  logic        rd,
  input  logic        wp,
  input  logic [7:0]  dq_in,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        rb,
  output logic        erase_req,
  output logic [11:0] erase_blk
);

  localparam int MAX_CYC = (BUSY_CYCLES > RST_CYCLES) ? BUSY_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state, state_n;
  logic             wr_q;
  logic [11:0]      blk, blk_n;
  logic             fail, fail_n;
  logic             stat_mode, stat_n;
  logic             accept, rst_cmd;
  logic             lat, cmd_lat, addr_lat, busy;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;

  // A strobe latches on the sampled 0->1 edge of wr while the target is selected.
  assign lat      = ce & wr & ~wr_q;
  assign cmd_lat  = lat & cle & ~ale;
  assign addr_lat = lat & ~cle & ale;
  assign busy     = (state == BUSY_ERASE) || (state == BUSY_RST);
  assign rb       = ~busy;
  assign dq_oe    = stat_mode & ce & ~rd;

  // Reset commands reload the timer with their own window, accepted erases with theirs.
  assign timer_value = rst_cmd ? CNT_W'(RST_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);

  nand_busy_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (accept | rst_cmd),
    .value (timer_value),
    .done  (timer_done)
  );

  // State register.
  // NOTE: async reset puts the FSM in IDLE immediately, which also releases rb without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode; read-status commands never move the sequence.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    blk_n   = blk;
    fail_n  = fail;
    accept  = 1'b0;
    rst_cmd = 1'b0;
    if (cmd_lat && dq_in == CMD_RESET) begin
      state_n = BUSY_RST;
      rst_cmd = 1'b1;
    end else begin
      case (state)
        BUSY_ERASE: if (timer_done) state_n = IDLE;
        BUSY_RST: begin
          if (timer_done) begin
            state_n = IDLE;
            fail_n  = 1'b0;
          end
        end
        default: begin
          if (cmd_lat && dq_in != CMD_STATUS) begin
            if (dq_in == CMD_ERASE1) begin
              state_n = ADDR1;
              fail_n  = 1'b0;
            end else if (dq_in == CMD_ERASE2 && state == CONFIRM) begin
              if (wp && (32'(blk) < 32'(NUM_BLOCKS))) begin
                state_n = BUSY_ERASE;
                accept  = 1'b1;
              end else begin
                state_n = IDLE;
                fail_n  = 1'b1;
              end
            end else begin
              state_n = IDLE;
            end
          end else if (addr_lat) begin
            case (state)
              ADDR1: state_n = ADDR2;
              ADDR2: begin
                state_n    = ADDR3;
                blk_n[7:0] = dq_in;
              end
              ADDR3: begin
                state_n     = CONFIRM;
                blk_n[11:8] = dq_in[3:0];
              end
              default: state_n = IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Status mode: set by 70h, cleared by any other honoured command (only FFh while busy).
  always_comb begin
    stat_n = stat_mode;
    if (cmd_lat) begin
      if (dq_in == CMD_STATUS)                stat_n = 1'b1;
      else if (dq_in == CMD_RESET || !busy)   stat_n = 1'b0;
    end
  end

  // Datapath registers: strobe history, block address, flags, erase handoff, status byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q      <= 1'b1;
      blk       <= '0;
      fail      <= 1'b0;
      stat_mode <= 1'b0;
      erase_req <= 1'b0;
      erase_blk <= '0;
      dq_out    <= 8'h00;
    end else begin
      wr_q      <= wr;
      blk       <= blk_n;
      fail      <= fail_n;
      stat_mode <= stat_n;
      erase_req <= accept;
      if (accept) erase_blk <= blk;
      dq_out    <= status_byte(wp, rb, fail);
    end
  end

endmodule
